// File: rtl/packet_decoder.sv
// USB packet decoder: classifies PID, checks token CRC5 and data CRC16, and strips CRC from the data payload.
// Optional SOF decoding is enabled by defining USB_SOF_DECODE_EN.
module packet_decoder (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_tvalid_i,
    input  logic        rx_tlast_i,
    input  logic [7:0]  rx_tdata_i,
    output logic        crc_error_o,
    output logic        eop_recv_o,
    output logic [3:0]  usb_pid_o,
    output logic        hsk_recv_o,
    output logic        usb_recv_o,
    output logic        tok_recv_o,
    output logic        tok_ping_o,
    output logic [6:0]  tok_addr_o,
    output logic [3:0]  tok_endp_o,
    output logic        sof_recv_o,
    output logic [10:0] sof_frame_o,
    output logic        m_tvalid_o,
    output logic        m_tlast_o,
    output logic [7:0]  m_tdata_o,
    output logic [2:0]  dbg_state
);
    typedef enum logic [2:0] {IDLE, TOKEN, DATA, HSK, DROP} state_t;

    state_t      state, next_state;
    logic [4:0]  crc5;
    logic [15:0] crc16;
    logic [4:0]  crc5_nxt;
    logic [15:0] crc16_nxt;
    logic [1:0]  tok_cnt;
    logic [1:0]  dcnt;
    logic [7:0]  byte1;
    logic [7:0]  d0, d1;
    logic        pid_ok;
    logic        tok_good, tok_bad, data_good, data_bad, hsk_good, eop;
`ifdef USB_SOF_DECODE_EN
    logic        sof_good;
`endif

    // Both CRCs shift MSB-out with bits taken LSB-first; a clean packet leaves a fixed residual.
    function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] d);
        logic [4:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = {r[3:0], 1'b0} ^ (((d[i] ^ r[4]) == 1'b1) ? 5'b00101 : 5'b00000);
        return r;
    endfunction

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = {r[14:0], 1'b0} ^ (((d[i] ^ r[15]) == 1'b1) ? 16'h8005 : 16'h0000);
        return r;
    endfunction

    assign dbg_state = state;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        tok_good   = 1'b0;
        tok_bad    = 1'b0;
        data_good  = 1'b0;
        data_bad   = 1'b0;
        hsk_good   = 1'b0;
        eop        = 1'b0;
`ifdef USB_SOF_DECODE_EN
        sof_good   = 1'b0;
`endif
        pid_ok    = (rx_tdata_i[7:4] == ~rx_tdata_i[3:0]);
        crc5_nxt  = crc5_byte(crc5, rx_tdata_i);
        crc16_nxt = crc16_byte(crc16, rx_tdata_i);
        if (rx_tvalid_i) begin
            eop = rx_tlast_i;
            case (state)
                IDLE: begin
                    if (!pid_ok) next_state = DROP;
                    else begin
                        // A PID carrying tlast is a one-byte packet: only a handshake is legal.
                        case (rx_tdata_i[3:0])
                            4'h1, 4'h9, 4'hD, 4'h4: begin next_state = TOKEN; tok_bad = rx_tlast_i; end
`ifdef USB_SOF_DECODE_EN
                            4'h5:                   begin next_state = TOKEN; tok_bad = rx_tlast_i; end
`endif
                            4'h3, 4'hB, 4'h7, 4'hF: begin next_state = DATA; data_bad = rx_tlast_i; end
                            4'h2, 4'hA, 4'hE, 4'h6: begin next_state = HSK; hsk_good = rx_tlast_i; end
                            default:                next_state = DROP;
                        endcase
                    end
                end
                TOKEN: begin
                    if (rx_tlast_i) begin
                        if (tok_cnt == 2'd1 && crc5_nxt == 5'b01100) begin
                            tok_good = 1'b1;
`ifdef USB_SOF_DECODE_EN
                            if (usb_pid_o == 4'h5) begin
                                tok_good = 1'b0;
                                sof_good = 1'b1;
                            end
`endif
                        end else begin
                            tok_bad = 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (rx_tlast_i) begin
                        if (dcnt != 2'd0 && crc16_nxt == 16'h800D) data_good = 1'b1;
                        else                                       data_bad  = 1'b1;
                    end
                end
                default: ;
            endcase
            if (rx_tlast_i) next_state = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            crc_error_o <= 1'b0;
            eop_recv_o  <= 1'b0;
            usb_pid_o   <= 4'h0;
            hsk_recv_o  <= 1'b0;
            usb_recv_o  <= 1'b0;
            tok_recv_o  <= 1'b0;
            tok_ping_o  <= 1'b0;
            tok_addr_o  <= 7'h0;
            tok_endp_o  <= 4'h0;
            m_tvalid_o  <= 1'b0;
            m_tlast_o   <= 1'b0;
            m_tdata_o   <= 8'h0;
            crc5        <= 5'h0;
            crc16       <= 16'h0;
            tok_cnt     <= 2'd0;
            dcnt        <= 2'd0;
            byte1       <= 8'h0;
            d0          <= 8'h0;
            d1          <= 8'h0;
        end else begin
            crc_error_o <= tok_bad | data_bad;
            eop_recv_o  <= eop;
            hsk_recv_o  <= hsk_good;
            usb_recv_o  <= data_good;
            tok_recv_o  <= tok_good;
            m_tvalid_o  <= 1'b0;
            m_tlast_o   <= 1'b0;
            if (rx_tvalid_i) begin
                if (state == IDLE && pid_ok) begin
                    usb_pid_o <= rx_tdata_i[3:0];
                    crc5      <= 5'h1F;
                    crc16     <= 16'hFFFF;
                    tok_cnt   <= 2'd0;
                    dcnt      <= 2'd0;
                end
                if (state == TOKEN) begin
                    crc5 <= crc5_nxt;
                    if (tok_cnt == 2'd0) byte1 <= rx_tdata_i;
                    if (tok_cnt != 2'd3) tok_cnt <= tok_cnt + 2'd1;
                end
                if (state == DATA) begin
                    crc16 <= crc16_nxt;
                    // The oldest held byte is payload once two newer bytes exist behind it.
                    if (dcnt == 2'd2) begin
                        m_tvalid_o <= 1'b1;
                        m_tdata_o  <= d0;
                        m_tlast_o  <= rx_tlast_i;
                    end else begin
                        dcnt <= dcnt + 2'd1;
                    end
                    d0 <= d1;
                    d1 <= rx_tdata_i;
                end
            end
            if (tok_good) begin
                tok_addr_o <= byte1[6:0];
                tok_endp_o <= {rx_tdata_i[2:0], byte1[7]};
                tok_ping_o <= (usb_pid_o == 4'h4);
            end
        end
    end

`ifdef USB_SOF_DECODE_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            sof_recv_o  <= 1'b0;
            sof_frame_o <= 11'h0;
        end else begin
            sof_recv_o <= sof_good;
            if (sof_good) sof_frame_o <= {rx_tdata_i[2:0], byte1};
        end
    end
`else
    assign sof_recv_o  = 1'b0;
    assign sof_frame_o = 11'h0;
`endif
endmodule
